// File: rtl/map_table_pkg.sv
// Packet types shared by the rename map table and its neighbours (dispatch/RS, CDB, ROB).
package map_table_pkg;

    localparam int unsigned MT_REG_LEN = 5;
    localparam int unsigned MT_ROB_LEN = 32;
    localparam int unsigned MT_TW      = $clog2(MT_ROB_LEN);
    localparam int unsigned MT_XLEN    = 32;

    typedef struct packed {
        logic [MT_TW-1:0] tag;
        logic             valid;
    } reg_tag_t;

    typedef struct packed {
        logic [MT_REG_LEN-1:0] rs1_idx;
        logic [MT_REG_LEN-1:0] rs2_idx;
        logic [MT_REG_LEN-1:0] dest_reg_idx;
        reg_tag_t              dest_reg_tag;
    } rs2mt_packet_t;

    typedef struct packed {
        reg_tag_t           reg_tag;
        logic [MT_XLEN-1:0] reg_value;
    } cdb_packet_t;

    typedef struct packed {
        logic             retire;
        logic [MT_TW-1:0] head_idx;
    } rob2mt_packet_t;

    typedef struct packed {
        reg_tag_t rs1_tag;
        logic     rs1_ready;
        reg_tag_t rs2_tag;
        logic     rs2_ready;
    } mt2rs_packet_t;

endpackage

// File: rtl/map_table.sv
// Register-rename map table: newest producer tag per architectural register, plus
// a ready bit set by CDB broadcast; entries are freed when their ROB entry retires.
module map_table #(
    parameter int unsigned REG_LEN = map_table_pkg::MT_REG_LEN,
    parameter int unsigned ROB_LEN = map_table_pkg::MT_ROB_LEN,
    parameter int unsigned XLEN    = map_table_pkg::MT_XLEN
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wr_en,
    input  map_table_pkg::rs2mt_packet_t  rs2mt_packet_in,
    input  map_table_pkg::cdb_packet_t    cdb_packet_in,
    input  map_table_pkg::rob2mt_packet_t rob2mt_packet_in,
    output map_table_pkg::mt2rs_packet_t  mt2rs_packet_out
);

    localparam int unsigned NUM_REGS = 2 ** REG_LEN;
    localparam int unsigned TW       = $clog2(ROB_LEN);

    typedef struct packed {
        logic [TW-1:0] tag;
        logic          valid;
        logic          ready;
    } entry_t;

    entry_t table_q [NUM_REGS];
    entry_t table_d [NUM_REGS];

    logic [NUM_REGS-1:0] write_hit;
    logic [NUM_REGS-1:0] retire_hit;
    logic [NUM_REGS-1:0] cdb_hit;

    logic                write_fire;
    logic [REG_LEN-1:0]  dest_idx;
    logic [TW-1:0]       dest_tag;
    logic                cdb_fire;
    logic [TW-1:0]       cdb_tag;
    logic                retire_fire;
    logic [TW-1:0]       retire_tag;

    // Payload data never enters the table; only the tag half of the CDB matters here.
    logic [XLEN-1:0]     unused_cdb_value;

    assign unused_cdb_value = cdb_packet_in.reg_value;

    assign write_fire  = wr_en && rs2mt_packet_in.dest_reg_tag.valid;
    assign dest_idx    = rs2mt_packet_in.dest_reg_idx;
    assign dest_tag    = rs2mt_packet_in.dest_reg_tag.tag;
    assign cdb_fire    = cdb_packet_in.reg_tag.valid;
    assign cdb_tag     = cdb_packet_in.reg_tag.tag;
    assign retire_fire = rob2mt_packet_in.retire;
    assign retire_tag  = rob2mt_packet_in.head_idx;

    // Per-entry match vectors; tag matches only count against live mappings.
    always_comb begin
        write_hit  = '0;
        retire_hit = '0;
        cdb_hit    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            write_hit[i]  = write_fire && (dest_idx == REG_LEN'(i));
            retire_hit[i] = retire_fire && table_q[i].valid && (table_q[i].tag == retire_tag);
            cdb_hit[i]    = cdb_fire && table_q[i].valid && (table_q[i].tag == cdb_tag);
        end
    end

    // Next state: a new rename beats a retire clear, which beats a ready-set.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            table_d[i] = table_q[i];
            if (write_hit[i]) begin
                table_d[i].tag   = dest_tag;
                table_d[i].valid = 1'b1;
                table_d[i].ready = 1'b0;
            end else if (retire_hit[i]) begin
                table_d[i] = '0;
            end else if (cdb_hit[i]) begin
                table_d[i].ready = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    // Lookup sees registered state only: no bypass of this cycle's write or CDB.
    entry_t rs1_entry;
    entry_t rs2_entry;

    assign rs1_entry = table_q[rs2mt_packet_in.rs1_idx];
    assign rs2_entry = table_q[rs2mt_packet_in.rs2_idx];

    assign mt2rs_packet_out.rs1_tag.tag   = rs1_entry.tag;
    assign mt2rs_packet_out.rs1_tag.valid = rs1_entry.valid;
    assign mt2rs_packet_out.rs1_ready     = rs1_entry.ready;
    assign mt2rs_packet_out.rs2_tag.tag   = rs2_entry.tag;
    assign mt2rs_packet_out.rs2_tag.valid = rs2_entry.valid;
    assign mt2rs_packet_out.rs2_ready     = rs2_entry.ready;

endmodule

// File: tb/tb_map_table.sv
// Directed, table-driven bench for map_table: each row drives one cycle and checks
// the same-cycle lookup against hand-computed {tag, valid, ready} triples.
module tb_map_table;
    import map_table_pkg::*;

    logic           clock;
    logic           reset;
    logic           wr_en;
    rs2mt_packet_t  rs2mt;
    cdb_packet_t    cdb;
    rob2mt_packet_t rob;
    mt2rs_packet_t  mt2rs;

    map_table dut (
        .clock            (clock),
        .reset            (reset),
        .wr_en            (wr_en),
        .rs2mt_packet_in  (rs2mt),
        .cdb_packet_in    (cdb),
        .rob2mt_packet_in (rob),
        .mt2rs_packet_out (mt2rs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       wr;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] dest;
        logic [4:0] dtag;
        logic       dv;
        logic [4:0] ctag;
        logic       cv;
        logic       ret;
        logic [4:0] head;
        logic [6:0] e1;   // {tag, valid, ready}
        logic [6:0] e2;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [6:0] trip(input logic [4:0] t, input logic v, input logic r);
        return {t, v, r};
    endfunction

    function automatic void add(input logic wr, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] dest, input logic [4:0] dtag, input logic dv,
                                input logic [4:0] ctag, input logic cv,
                                input logic ret, input logic [4:0] head,
                                input logic [6:0] e1, input logic [6:0] e2);
        vec_t v;
        v.wr = wr; v.rs1 = rs1; v.rs2 = rs2; v.dest = dest; v.dtag = dtag; v.dv = dv;
        v.ctag = ctag; v.cv = cv; v.ret = ret; v.head = head; v.e1 = e1; v.e2 = e2;
        vq.push_back(v);
    endfunction

    function automatic logic [6:0] got1();
        return {mt2rs.rs1_tag.tag, mt2rs.rs1_tag.valid, mt2rs.rs1_ready};
    endfunction

    function automatic logic [6:0] got2();
        return {mt2rs.rs2_tag.tag, mt2rs.rs2_tag.valid, mt2rs.rs2_ready};
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got tag=%0d valid=%0b ready=%0b, want tag=%0d valid=%0b ready=%0b",
                     name, got[6:2], got[1], got[0], exp[6:2], exp[1], exp[0]);
        end
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0;
        rs2mt = '0;
        cdb   = '0;
        rob   = '0;
    endtask

    task automatic drive(input vec_t v);
        wr_en                    = v.wr;
        rs2mt.rs1_idx            = v.rs1;
        rs2mt.rs2_idx            = v.rs2;
        rs2mt.dest_reg_idx       = v.dest;
        rs2mt.dest_reg_tag.tag   = v.dtag;
        rs2mt.dest_reg_tag.valid = v.dv;
        cdb.reg_tag.tag          = v.ctag;
        cdb.reg_tag.valid        = v.cv;
        cdb.reg_value            = 32'hDEAD_BEEF;
        rob.retire               = v.ret;
        rob.head_idx             = v.head;
    endtask

    localparam logic [6:0] Z = 7'd0;

    initial begin
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("reset_rs1", got1(), Z);
        check("reset_rs2", got2(), Z);
        reset = 1'b1;

        //   wr  rs1 rs2 dst dtag dv ctag cv ret head  exp rs1            exp rs2
        add(1, 1, 0, 1,  0, 1,  0, 0, 0,  0, Z,                Z);               // rename r1->0, no bypass
        add(1, 1, 2, 2,  2, 1,  0, 1, 0,  0, trip(0,1,0),      Z);               // CDB 0 not bypassed
        add(0, 1, 3, 3,  4, 1,  2, 1, 0,  0, trip(0,1,1),      Z);               // stall + CDB 2
        add(1, 3, 2, 5,  3, 1,  0, 0, 0,  0, Z,                trip(2,1,1));     // r3 untouched, r5->3
        add(1, 5, 2, 2,  9, 0,  0, 0, 0,  0, trip(3,1,0),      trip(2,1,1));     // dest valid low
        add(1, 5, 2, 5,  6, 1,  3, 1, 0,  0, trip(3,1,0),      trip(2,1,1));     // overwrite vs CDB 3
        add(1, 5, 2, 2,  7, 1,  0, 0, 0,  0, trip(6,1,0),      trip(2,1,1));     // r2->7
        add(0, 2, 5, 0,  0, 0,  7, 1, 0,  0, trip(7,1,0),      trip(6,1,0));     // CDB 7
        add(0, 2, 1, 0,  0, 0,  0, 0, 1,  7, trip(7,1,1),      trip(0,1,1));     // retire 7
        add(1, 2, 1, 1, 11, 1,  0, 0, 0,  0, Z,                trip(0,1,1));     // r1->11
        add(1, 1, 2, 1, 15, 1,  0, 0, 1, 11, trip(11,1,0),     Z);               // rename beats retire
        add(0, 1, 5, 0,  0, 0, 15, 1, 1, 15, trip(15,1,0),     trip(6,1,0));     // CDB+retire same entry
        add(0, 1, 5, 0,  0, 0, 20, 1, 1, 21, Z,                trip(6,1,0));     // unmatched tags
        add(1, 0, 5, 0, 31, 1,  0, 0, 0,  0, Z,                trip(6,1,0));     // r0 renamed normally
        add(0, 0, 5, 0,  0, 0,  6, 1, 0,  0, trip(31,1,0),     trip(6,1,0));     // CDB 6
        add(0, 0, 5, 0,  0, 0,  0, 1, 0,  0, trip(31,1,0),     trip(6,1,1));     // CDB 0 vs cleared entries
        add(0, 1, 2, 0,  0, 0,  0, 0, 0,  0, Z,                Z);               // cleared stay not ready

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clock);
            drive(vq[i]);
            #1;
            check($sformatf("vec%0d_rs1", i), got1(), vq[i].e1);
            check($sformatf("vec%0d_rs2", i), got2(), vq[i].e2);
        end

        // Asynchronous reset mid-stream, asserted away from any clock edge.
        @(negedge clock);
        idle_inputs();
        rs2mt.rs1_idx = 5'd0;
        rs2mt.rs2_idx = 5'd5;
        #1;
        check("pre_reset_r0", got1(), trip(31,1,0));
        check("pre_reset_r5", got2(), trip(6,1,1));
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_r0", got1(), Z);
        check("async_reset_r5", got2(), Z);

        // Release, confirm the first lookup is clean, then a fresh rename lands.
        @(negedge clock);
        reset = 1'b1;
        wr_en = 1'b1;
        rs2mt.dest_reg_idx       = 5'd5;
        rs2mt.dest_reg_tag.tag   = 5'd9;
        rs2mt.dest_reg_tag.valid = 1'b1;
        #1;
        check("post_reset_r5", got2(), Z);
        @(negedge clock);
        idle_inputs();
        rs2mt.rs1_idx = 5'd0;
        rs2mt.rs2_idx = 5'd5;
        #1;
        check("post_reset_r0", got1(), Z);
        check("post_reset_rename_r5", got2(), trip(9,1,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/map_table.md
# map_table

Register-rename map table for the out-of-order core. It tracks, for each architectural register, which ROB entry (tag) will produce its newest value, and whether that value has already been broadcast on the CDB. It sits between dispatch/RS, the CDB and the ROB, and it answers source-operand lookups for the instruction being dispatched.

## Interface
Parameters:
- `REG_LEN`, default 5: architectural register index width; the table has 2^REG_LEN = 32 entries.
- `ROB_LEN`, default 32: number of ROB entries; tag width TW = $clog2(ROB_LEN) = 5.
- `XLEN`, default 32: data width; only present inside the CDB packet.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low. While low, all entries are cleared.
- `wr_en`  in  1: dispatch write enable. Low means a stall, and no rename is written.
- `rs2mt_packet_in`  in  struct: `rs1_idx`[REG_LEN], `rs2_idx`[REG_LEN], `dest_reg_idx`[REG_LEN], `dest_reg_tag`{`tag`[TW], `valid`}.
- `cdb_packet_in`  in  struct: `reg_tag`{`tag`[TW], `valid`}, `reg_value`[XLEN]. `reg_value` is unused.
- `rob2mt_packet_in`  in  struct: `retire`[1], `head_idx`[TW], which is the tag of the ROB entry retiring this cycle.
- `mt2rs_packet_out`  out  struct: `rs1_tag`{`tag`,`valid`}, `rs1_ready`, `rs2_tag`{`tag`,`valid`}, `rs2_ready`.

## Operation
- Each entry holds `tag`[TW], `valid` (a rename exists) and `ready` (the producer has completed on the CDB).
- A cleared entry is all zero: tag 0, valid 0, ready 0.
- Register 0 gets no special treatment; it is renamed like any other register.
- **Lookup (combinational):**
  - The rs1 output is the entry at `rs1_idx`: tag, valid, ready. rs2 works the same way using `rs2_idx`.
  - Lookup reads the current registered state only.
  - There is no bypass of the same-cycle dest write.
  - There is no bypass of the same-cycle CDB broadcast.
- **Rename write:** if `wr_en` && `dest_reg_tag.valid`, the entry at `dest_reg_idx` becomes {tag = `dest_reg_tag.tag`, valid = 1, ready = 0}.
- **CDB:** if `cdb.reg_tag.valid`, every valid entry whose tag equals `cdb.reg_tag.tag` sets ready = 1. This applies regardless of `wr_en`.
- **Retire:** if `rob2mt.retire`, every valid entry whose tag equals `head_idx` is cleared to zero. After that, the register's value lives in the architectural register file.
- **Per-entry priority within one cycle:** rename write > retire clear > CDB ready-set > hold.
  - A dest write to an entry whose old tag matches the CDB tag leaves that entry not ready.
  - A dest write to an entry whose old tag matches the retiring tag leaves the new mapping intact.
  - If CDB and retire both hit the same entry, the entry is cleared.
- CDB or retire tags that match no valid entry have no effect.

## Timing
- Outputs are combinational from the state and from `rs1_idx`/`rs2_idx`. They are valid in the same cycle the indices are presented.
- All updates (write, ready, clear) become visible on the cycle after the rising edge.
- **Reset:**
  - Asynchronous assertion immediately forces all entries to zero.
  - All outputs are then 0: tag 0, valid 0, ready 0.
  - Reset asserted mid-stream discards all mappings.
  - After deassertion, the first lookup returns zeros.
- There is no backpressure and no handshake. The block accepts every cycle's inputs.

## Test plan
- **Reset, rename, then read:**
  - After reset, rename r1 to tag 0 (dispatch rs1 = 1, dest = 1). The rs1 lookup that same cycle returns (0,0,0).
  - The next cycle, reading r1 returns (tag 0, valid 1, ready 0).
- **CDB without bypass:**
  - With r1 mapped to tag 0, send CDB tag 0 valid. The same-cycle r1 lookup still returns ready 0.
  - The next cycle it returns (0,1,1).
- **Stall:**
  - Set `wr_en` = 0 with dest r3 tag 4, and drive CDB tag 2 valid while r2 is mapped to tag 2.
  - Next cycle: r3 is unchanged, and r2 reads (2,1,1).
- **Dest valid low:**
  - Set `wr_en` = 1, `dest_reg_tag.valid` = 0, dest r2. The r2 mapping is unchanged.
- **Overwrite vs CDB:**
  - r5 is mapped to tag 3. In the same cycle, rename r5 to tag 6 and send CDB tag 3.
  - Next cycle, r5 reads (6,1,0).
- **Retire:**
  - r2 is mapped to tag 7 and ready. Retire with `head_idx` 7; next cycle, r2 reads (0,0,0).
  - r1 is mapped to tag 11. In the same cycle, rename r1 to tag 15 and retire `head_idx` 11; next cycle, r1 reads (15,1,0).
  - Then assert reset: all lookups return (0,0,0).
